// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioning blocks.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 0;
    localparam int DEF_REPEAT_PERIOD   = 8;

    // Width needed to hold max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser for an asynchronous input pin.
module button_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync
);

    logic sync1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync  <= sync1;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw push-button into a registered level and a one-cycle press
// strobe, with optional auto-repeat while the button stays held.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic pressed,
    output logic press_pulse
);

    localparam int CNT_W   = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int RPT_MAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam bit               SINGLE      = (DEBOUNCE_CYCLES == 1);
    localparam bit               RPT_EN      = (REPEAT_DELAY > 0);

    logic             btn_s;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             phase_q, phase_d;
    logic             pressed_d, pulse_d;

    button_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (button),
        .sync  (btn_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rpt_q       <= '0;
            phase_q     <= 1'b0;
            pressed     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rpt_q       <= rpt_d;
            phase_q     <= phase_d;
            pressed     <= pressed_d;
            press_pulse <= pulse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        phase_d   = phase_q;
        pressed_d = pressed;
        pulse_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    if (SINGLE) begin
                        state_d   = HELD;
                        cnt_d     = '0;
                        rpt_d     = '0;
                        phase_d   = 1'b0;
                        pressed_d = 1'b1;
                        pulse_d   = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end

            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    rpt_d     = '0;
                    phase_d   = 1'b0;
                    pressed_d = 1'b1;
                    pulse_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HELD: begin
                if (!btn_s) begin
                    if (SINGLE) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        pressed_d = 1'b0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (RPT_EN) begin
                    // Phase 0 waits out the initial delay, phase 1 the repeat period.
                    if (!phase_q) begin
                        if (rpt_q == DELAY_LAST) begin
                            pulse_d = 1'b1;
                            rpt_d   = '0;
                            phase_d = 1'b1;
                        end else begin
                            rpt_d = rpt_q + RPT_W'(1);
                        end
                    end else if (rpt_q == PERIOD_LAST) begin
                        pulse_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
                end
            end

            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pressed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: three configurations share one pin
// and are compared against a run-length reference model every cycle.
module tb_button_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic button;
    logic a_pressed, a_pulse;
    logic r_pressed, r_pulse;
    logic o_pressed, o_pulse;

    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    button_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .button(button), .pressed(a_pressed), .press_pulse(a_pulse));
    button_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut_r (
        .clk(clk), .rst_n(rst_n), .button(button), .pressed(r_pressed), .press_pulse(r_pulse));
    button_debounce #(.DEBOUNCE_CYCLES(1), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)) dut_o (
        .clk(clk), .rst_n(rst_n), .button(button), .pressed(o_pressed), .press_pulse(o_pulse));

    // Reference: accept a level once the last d synchronised samples agree;
    // repeats fire after rd and then every rp cycles held with a steady high sample.
    typedef struct {
        logic s1;
        logic s2;
        logic prev;
        logic level;
        logic pulse;
        int   run1;
        int   run0;
        int   n;
    } mdl_t;

    mdl_t m [3];

    function automatic mdl_t step(input mdl_t cur, input logic b, input int d, input int rd, input int rp);
        mdl_t r;
        logic smp;
        r     = cur;
        smp   = cur.s2;
        r.s1  = b;
        r.s2  = cur.s1;
        r.pulse = 1'b0;
        if (smp) begin
            r.run1 = cur.run1 + 1;
            r.run0 = 0;
        end else begin
            r.run0 = cur.run0 + 1;
            r.run1 = 0;
        end
        if (!cur.level) begin
            if (r.run1 >= d) begin
                r.level = 1'b1;
                r.pulse = 1'b1;
                r.n     = 0;
            end
        end else if (r.run0 >= d) begin
            r.level = 1'b0;
        end else if (smp && cur.prev && rd > 0) begin
            r.n = cur.n + 1;
            if (r.n == rd || (r.n > rd && ((r.n - rd) % rp) == 0))
                r.pulse = 1'b1;
        end
        r.prev = smp;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m[i] <= '{default: 0};
        end else begin
            m[0] <= step(m[0], button, 4, 0, 8);
            m[1] <= step(m[1], button, 4, 20, 8);
            m[2] <= step(m[2], button, 1, 0, 8);
        end
    end

    task automatic idle(input int cycles);
        button = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_pressed, a_pulse, r_pressed, r_pulse, o_pressed, o_pulse} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b exp 000000",
                     {a_pressed, a_pulse, r_pressed, r_pulse, o_pressed, o_pulse});
        end
        button = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_pressed, a_pulse, r_pressed, r_pulse, o_pressed, o_pulse} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_hold_button got %b exp 000000",
                     {a_pressed, a_pulse, r_pressed, r_pulse, o_pressed, o_pulse});
        end
        button = 1'b0;
        rst_n  = 1'b1;
        idle(12);
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int first  = -1;
        for (int c = 0; c < 40; c++) begin
            button = (c < 20);
            @(negedge clk);
            n_cmp++;
            if ({a_pressed, a_pulse} !== {m[0].level, m[0].pulse}) begin
                n_bad++;
                $display("FAIL clean_press c=%0d got %b%b exp %b%b", c, a_pressed, a_pulse, m[0].level, m[0].pulse);
            end
            if (a_pulse === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (c == 24 || c == 25) begin
                n_cmp++;
                if (a_pressed !== (c == 24)) begin
                    n_bad++;
                    $display("FAIL clean_release c=%0d got %b exp %b", c, a_pressed, (c == 24));
                end
            end
        end
        n_cmp++;
        if (pulses !== 1 || first !== 5) begin
            n_bad++;
            $display("FAIL clean_pulse got count=%0d at=%0d exp count=1 at=5", pulses, first);
        end
        idle(12);
    endtask

    task automatic test_bounce_reject();
        int pulses = 0;
        int first  = -1;
        for (int c = 0; c < 48; c++) begin
            button = (c < 20) ? ((c % 4) != 3) : (c < 36);
            @(negedge clk);
            n_cmp++;
            if ({a_pressed, a_pulse} !== {m[0].level, m[0].pulse}) begin
                n_bad++;
                $display("FAIL bounce_reject c=%0d got %b%b exp %b%b", c, a_pressed, a_pulse, m[0].level, m[0].pulse);
            end
            if (a_pulse === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        n_cmp++;
        if (pulses !== 1 || first !== 25) begin
            n_bad++;
            $display("FAIL bounce_pulse got count=%0d at=%0d exp count=1 at=25", pulses, first);
        end
        idle(12);
    endtask

    task automatic test_release_bounce();
        int pulses = 0;
        int drops  = 0;
        for (int c = 0; c < 56; c++) begin
            if (c < 10)      button = 1'b1;
            else if (c < 30) button = ((c - 10) % 5) >= 2;
            else             button = (c < 40);
            @(negedge clk);
            n_cmp++;
            if ({a_pressed, a_pulse} !== {m[0].level, m[0].pulse}) begin
                n_bad++;
                $display("FAIL release_bounce c=%0d got %b%b exp %b%b", c, a_pressed, a_pulse, m[0].level, m[0].pulse);
            end
            if (a_pulse === 1'b1) pulses++;
            if (c >= 5 && c < 45 && a_pressed !== 1'b1) drops++;
        end
        n_cmp++;
        if (pulses !== 1 || drops !== 0 || a_pressed !== 1'b0) begin
            n_bad++;
            $display("FAIL release_hold got pulses=%0d drops=%0d end=%b exp pulses=1 drops=0 end=0",
                     pulses, drops, a_pressed);
        end
        idle(12);
    endtask

    task automatic test_auto_repeat();
        int got[$];
        int exp[$];
        exp.push_back(5);
        for (int t = 25; t <= 61; t += 8) exp.push_back(t);
        for (int c = 0; c < 84; c++) begin
            button = (c < 60);
            @(negedge clk);
            n_cmp++;
            if ({r_pressed, r_pulse} !== {m[1].level, m[1].pulse}) begin
                n_bad++;
                $display("FAIL auto_repeat c=%0d got %b%b exp %b%b", c, r_pressed, r_pulse, m[1].level, m[1].pulse);
            end
            if (r_pulse === 1'b1) got.push_back(c);
        end
        n_cmp++;
        if (got.size() !== exp.size()) begin
            n_bad++;
            $display("FAIL repeat_count got %0d exp %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_cmp++;
                if (got[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL repeat_time idx=%0d got %0d exp %0d", i, got[i], exp[i]);
                end
            end
        end
        idle(12);
    endtask

    task automatic test_reset_mid_hold();
        int pulses = 0;
        int first  = -1;
        button = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (a_pressed !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_hold_pre got %b exp 1", a_pressed);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_pressed, a_pulse, r_pressed, r_pulse, o_pressed, o_pulse} !== 6'b0) begin
            n_bad++;
            $display("FAIL mid_hold_async got %b exp 000000",
                     {a_pressed, a_pulse, r_pressed, r_pulse, o_pressed, o_pulse});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_pressed, a_pulse} !== {m[0].level, m[0].pulse}) begin
                n_bad++;
                $display("FAIL mid_hold_after c=%0d got %b%b exp %b%b", c, a_pressed, a_pulse, m[0].level, m[0].pulse);
            end
            if (a_pulse === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        n_cmp++;
        if (pulses !== 1 || first !== 5) begin
            n_bad++;
            $display("FAIL mid_hold_pulse got count=%0d at=%0d exp count=1 at=5", pulses, first);
        end
        idle(12);
    endtask

    task automatic test_single_cycle();
        int pulses = 0;
        int highs  = 0;
        int first  = -1;
        for (int c = 0; c < 30; c++) begin
            button = (c % 10) == 0;
            @(negedge clk);
            n_cmp++;
            if ({o_pressed, o_pulse} !== {m[2].level, m[2].pulse}) begin
                n_bad++;
                $display("FAIL single_cycle c=%0d got %b%b exp %b%b", c, o_pressed, o_pulse, m[2].level, m[2].pulse);
            end
            if (o_pulse === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (o_pressed === 1'b1) highs++;
        end
        n_cmp++;
        if (pulses !== 3 || highs !== 3 || first !== 2) begin
            n_bad++;
            $display("FAIL single_counts got pulses=%0d highs=%0d first=%0d exp 3 3 2", pulses, highs, first);
        end
        idle(12);
    endtask

    task automatic test_random();
        int   left = 0;
        logic lvl  = 1'b0;
        for (int c = 0; c < 900; c++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 6);
            end
            left--;
            button = lvl;
            @(negedge clk);
            n_cmp++;
            if ({a_pressed, a_pulse, r_pressed, r_pulse, o_pressed, o_pulse} !==
                {m[0].level, m[0].pulse, m[1].level, m[1].pulse, m[2].level, m[2].pulse}) begin
                n_bad++;
                $display("FAIL random c=%0d got %b exp %b", c,
                         {a_pressed, a_pulse, r_pressed, r_pulse, o_pressed, o_pulse},
                         {m[0].level, m[0].pulse, m[1].level, m[1].pulse, m[2].level, m[2].pulse});
            end
        end
        idle(12);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        button = 1'b0;
        rst_n  = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_release_bounce();
        test_auto_repeat();
        test_reset_mid_hold();
        test_single_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
